// File: rtl/regs_bridge_pkg.sv
// regs_bridge_pkg: opcodes, FSM encoding and sizing shared by the host bridge and its testbench.
package regs_bridge_pkg;
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DUMP  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;
  localparam int NUM_REGS_DEFAULT = 16;
  typedef enum logic [2:0] {
    ST_IDLE, ST_READ, ST_WRITE, ST_RESP, ST_DUMP_RD, ST_DUMP_RSP
  } state_t;
endpackage

// File: rtl/regs_wr_arb.sv
// regs_wr_arb: core-priority write-port mux shared by register file write initiators.
module regs_wr_arb #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              core_en,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_data,
  input  logic              req_en,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);
  always_comb begin
    wr_en   = core_en | req_en;
    wr_addr = core_en ? core_addr : req_addr;
    wr_data = core_en ? core_data : req_data;
  end
endmodule

// File: rtl/regs_host_bridge.sv
// regs_host_bridge: host command initiator (read/write/dump) for the register file.
module regs_host_bridge
  import regs_bridge_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_err,
  input  logic              core_write_en,
  input  logic [ADDR_W-1:0] core_write_addr,
  input  logic [DATA_W-1:0] core_write_data,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_addr,
  output logic [DATA_W-1:0] reg_write_data,
  output logic [ADDR_W-1:0] reg_read_addr_a,
  input  logic [DATA_W-1:0] reg_read_data_a
);
  state_t              state_q, state_d;
  logic                up_q, up_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_last_q, rsp_last_d;
  logic                rsp_err_q, rsp_err_d;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      up_q       <= 1'b0;
      addr_q     <= '0;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      up_q       <= up_d;
      addr_q     <= addr_d;
      rsp_data_q <= rsp_data_d;
      rsp_last_q <= rsp_last_d;
      rsp_err_q  <= rsp_err_d;
    end
  end
  // addr_q holds the command address, and doubles as the walk counter during a dump
  always_comb begin
    state_d    = state_q;
    up_d       = 1'b1;
    addr_d     = addr_q;
    rsp_data_d = rsp_data_q;
    rsp_last_d = rsp_last_q;
    rsp_err_d  = rsp_err_q;
    cmd_ready  = up_q && state_q == ST_IDLE;
    case (state_q)
      ST_IDLE: if (cmd_valid && cmd_ready) begin
        addr_d     = cmd_op == OP_DUMP ? '0 : cmd_addr;
        rsp_data_d = cmd_op == OP_RSVD ? '0 : cmd_data;
        rsp_last_d = cmd_op != OP_DUMP;
        rsp_err_d  = cmd_op == OP_RSVD;
        state_d    = cmd_op == OP_READ  ? ST_READ  :
                     cmd_op == OP_WRITE ? ST_WRITE :
                     cmd_op == OP_DUMP  ? ST_DUMP_RD : ST_RESP;
      end
      ST_READ: begin
        rsp_data_d = reg_read_data_a;
        state_d    = ST_RESP;
      end
      ST_WRITE: state_d = core_write_en ? ST_WRITE : ST_RESP;
      ST_RESP: state_d = rsp_ready ? ST_IDLE : ST_RESP;
      ST_DUMP_RD: begin
        rsp_data_d = reg_read_data_a;
        rsp_last_d = addr_q == ADDR_W'(NUM_REGS - 1);
        state_d    = ST_DUMP_RSP;
      end
      ST_DUMP_RSP: if (rsp_ready) begin
        state_d = rsp_last_q ? ST_IDLE : ST_DUMP_RD;
        addr_d  = rsp_last_q ? addr_q : addr_q + ADDR_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end
  assign rsp_valid       = state_q == ST_RESP || state_q == ST_DUMP_RSP;
  assign rsp_addr        = addr_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_last        = rsp_last_q;
  assign rsp_err         = rsp_err_q;
  assign reg_read_addr_a = addr_q;
  regs_wr_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_arb (
    .core_en   (core_write_en),
    .core_addr (core_write_addr),
    .core_data (core_write_data),
    .req_en    (state_q == ST_WRITE),
    .req_addr  (addr_q),
    .req_data  (rsp_data_q),
    .wr_en     (reg_write_en),
    .wr_addr   (reg_write_addr),
    .wr_data   (reg_write_data)
  );
endmodule

// File: tb/tb_regs_host_bridge.sv
// tb_regs_host_bridge: directed plus random checks of the host bridge against a register-file memory model.
module tb_regs_host_bridge;
  import regs_bridge_pkg::*;
  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_last, rsp_err;
  logic [1:0] cmd_op;
  logic [3:0] cmd_addr, rsp_addr, core_write_addr, reg_write_addr, reg_read_addr_a;
  logic [7:0] cmd_data, rsp_data, core_write_data, reg_write_data, reg_read_data_a;
  logic       core_write_en, reg_write_en;
  logic [7:0] rf [16];
  logic [7:0] ref_m [16];
  int         passed = 0, total = 0, wr_cnt = 0;
  logic [3:0] ra;
  logic [7:0] rd, old, cd;
  logic       rl, re;
  int         w0;
  regs_host_bridge dut (
    .clk(clk), .arst_n(arst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .core_write_en(core_write_en), .core_write_addr(core_write_addr),
    .core_write_data(core_write_data),
    .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr),
    .reg_write_data(reg_write_data),
    .reg_read_addr_a(reg_read_addr_a), .reg_read_data_a(reg_read_data_a)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (reg_write_en === 1'b1) rf[reg_write_addr] <= reg_write_data;
  always @(posedge clk) if (reg_write_en === 1'b1) wr_cnt <= wr_cnt + 1;
  assign reg_read_data_a = rf[reg_read_addr_a];
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic core_wr(input logic [3:0] a, input logic [7:0] d);
    core_write_en = 1'b1; core_write_addr = a; core_write_data = d;
    @(negedge clk);
    core_write_en = 1'b0;
    ref_m[a] = d;
  endtask
  task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("cmd_ready_drop", cmd_ready, 0);
  endtask
  task automatic get_rsp(input int stall, output logic [3:0] a, output logic [7:0] d,
                         output logic l, output logic e);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("rsp_valid_wait", rsp_valid, 1);
    a = rsp_addr; d = rsp_data; l = rsp_last; e = rsp_err;
    repeat (stall) begin
      @(negedge clk);
      chk("rsp_hold", {rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err, cmd_ready},
          {1'b1, a, d, l, e, 1'b0});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask
  initial begin
    cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_data = 0; rsp_ready = 0;
    core_write_en = 0; core_write_addr = 0; core_write_data = 0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", {cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err, reg_read_addr_a, reg_write_en}, 0);
    arst_n = 1'b1;
    #1 chk("rdy_before_edge", cmd_ready, 0);
    @(negedge clk);
    chk("rdy_after_edge", cmd_ready, 1);
    for (int i = 0; i < 16; i++) core_wr(4'(i), 8'($urandom));
    // plain write with the core idle
    w0 = wr_cnt;
    send(OP_WRITE, 4'd3, 8'hA5);
    chk("wr_pulse", {reg_write_en, reg_write_addr, reg_write_data}, {1'b1, 4'd3, 8'hA5});
    @(negedge clk);
    chk("wr_pulse_end", reg_write_en, 0);
    chk("wr_one_cycle", wr_cnt - w0, 1);
    get_rsp(0, ra, rd, rl, re);
    chk("wr_rsp", {ra, rd, rl, re}, {4'd3, 8'hA5, 1'b1, 1'b0});
    ref_m[3] = 8'hA5;
    chk("wr_commit", rf[3], ref_m[3]);
    // write stalled behind four cycles of core writes
    core_write_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      core_write_addr = 4'($urandom); core_write_data = 8'($urandom);
      ref_m[core_write_addr] = core_write_data;
      if (k == 0) send(OP_WRITE, 4'd7, 8'h3C); else @(negedge clk);
      chk("core_pass", {reg_write_en, reg_write_addr, reg_write_data, rsp_valid},
          {1'b1, core_write_addr, core_write_data, 1'b0});
    end
    core_write_en = 1'b0;
    #1 chk("stall_release", {reg_write_en, reg_write_addr, reg_write_data}, {1'b1, 4'd7, 8'h3C});
    @(negedge clk);
    chk("stall_pulse_end", reg_write_en, 0);
    get_rsp(0, ra, rd, rl, re);
    chk("stall_rsp", {ra, rd, rl, re}, {4'd7, 8'h3C, 1'b1, 1'b0});
    ref_m[7] = 8'h3C;
    // read with latency and back-pressure
    core_wr(4'd5, 8'h5A);
    send(OP_READ, 4'd5, 8'h00);
    chk("rd_port_addr", reg_read_addr_a, 5);
    chk("rd_lat_early", rsp_valid, 0);
    @(negedge clk);
    chk("rd_lat", rsp_valid, 1);
    get_rsp(3, ra, rd, rl, re);
    chk("rd_rsp", {ra, rd, rl, re}, {4'd5, 8'h5A, 1'b1, 1'b0});
    // core write colliding with the capture edge returns the older value
    ra = 4'($urandom); old = ref_m[ra];
    send(OP_READ, ra, 8'h00);
    core_write_en = 1'b1; core_write_addr = ra; core_write_data = ~old;
    @(negedge clk);
    core_write_en = 1'b0;
    ref_m[ra] = ~old;
    get_rsp(0, ra, rd, rl, re);
    chk("rd_collide", rd, old);
    // full dump with random back-pressure
    for (int i = 0; i < 16; i++) core_wr(4'(i), 8'(i * 17));
    send(OP_DUMP, 4'($urandom), 8'h00);
    for (int i = 0; i < 16; i++) begin
      get_rsp(int'($urandom_range(0, 2)), ra, rd, rl, re);
      chk("dump_beat", {ra, rd, rl, re}, {4'(i), ref_m[i], i == 15, 1'b0});
    end
    chk("dump_done_rdy", {cmd_ready, rsp_valid}, 2'b10);
    // reserved opcode
    w0 = wr_cnt;
    send(OP_RSVD, 4'd4, 8'hFF);
    get_rsp(1, ra, rd, rl, re);
    chk("rsvd_rsp", {rd, rl, re}, {8'h00, 1'b1, 1'b1});
    chk("rsvd_no_write", wr_cnt - w0, 0);
    // random reads and writes
    repeat (24) begin
      ra = 4'($urandom); cd = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        send(OP_WRITE, ra, cd);
        ref_m[ra] = cd;
        get_rsp(int'($urandom_range(0, 2)), ra, rd, rl, re);
        chk("rand_wr", {rd, rl, re}, {cd, 1'b1, 1'b0});
      end else begin
        send(OP_READ, ra, cd);
        get_rsp(int'($urandom_range(0, 2)), ra, rd, rl, re);
        chk("rand_rd", {rd, rl, re}, {ref_m[ra], 1'b1, 1'b0});
      end
    end
    // reset in the middle of a dump
    send(OP_DUMP, 4'd0, 8'h00);
    for (int i = 0; i < 6; i++) get_rsp(0, ra, rd, rl, re);
    begin
      int n = 0;
      while (rsp_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    end
    chk("dump_beat6", {rsp_valid, rsp_addr}, {1'b1, 4'd6});
    #2 arst_n = 1'b0;
    #1 chk("abort_outputs", {cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err, reg_read_addr_a, reg_write_en}, 0);
    @(negedge clk);
    arst_n = 1'b1;
    w0 = wr_cnt;
    @(negedge clk);
    chk("abort_rdy", {cmd_ready, rsp_valid}, 2'b10);
    send(OP_READ, 4'd2, 8'h00);
    get_rsp(0, ra, rd, rl, re);
    chk("post_rst_rd", {ra, rd, rl, re}, {4'd2, ref_m[2], 1'b1, 1'b0});
    repeat (3) begin
      @(negedge clk);
      chk("no_residual", rsp_valid, 0);
    end
    chk("no_residual_wr", wr_cnt - w0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
